econ_infer_sched: RTL and testbench
===================================

ECON_INFER_SCHED -- requirements
Module: econ_infer_sched

Interface
REQ-001 SHALL have parameters, one per line:
- IN_W, 384, core input frame width
- OUT_W, 80, core output frame width
- DEPTH, 4, output FIFO depth (power of 2, 2..16); also the in-flight limit
- WD_CYC, 1024, watchdog timeout in cycles
REQ-002 SHALL have ports, one per line (name  direction  width  meaning):
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- cfg_start  in  1  pulse: begin run
- cfg_stop  in  1  pulse: stop accepting, drain
- cfg_count  in  16  frames per run; 0 = unlimited; sampled at start
- s_dat / s_vld / s_rdy  in/in/out  IN_W/1/1  upstream frames
- c_in_dat / c_in_vld / c_in_rdy  out/out/in  IN_W/1/1  core input channel
- p_vld / p_rdy  out/in  4/4  per-invocation param channels [w2,b2,w4,b4]
- c_out_dat / c_out_vld / c_out_rdy  in/in/out  OUT_W/1/1  core output channel
- m_dat / m_vld / m_rdy  out/out/in  OUT_W/1/1  downstream results
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse on DRAIN->IDLE
- err  out  1  sticky watchdog error
- frames_in / frames_out  out  16/16  frames issued / delivered this run

Function
REQ-003 SHALL implement states IDLE, RUN, DRAIN, HALT.
REQ-004 IDLE->RUN on cfg_start: clear frames_in, frames_out, err; latch cfg_count. cfg_start is ignored outside IDLE.
REQ-005 RUN->DRAIN on cfg_stop, or when frames_in reaches the latched count (count != 0) as the last frame is accepted. cfg_stop is ignored in IDLE and HALT.
REQ-006 DRAIN->IDLE when inflight == 0, all owed == 0 and the FIFO is empty; done pulses for exactly that cycle.
REQ-007 Any state->HALT when the watchdog expires; HALT exits only via reset.
REQ-008 c_in_vld = s_vld & RUN & (inflight + fifo_cnt < DEPTH); s_rdy = c_in_rdy & the same gate; c_in_dat = s_dat combinationally (zero added latency).
REQ-009 Issue event = c_in_vld & c_in_rdy. On issue: inflight +1, frames_in +1, and each owed[i] +1.
REQ-010 p_vld[i] = (owed[i] != 0) & state not in {IDLE, HALT}; a p_vld[i] & p_rdy[i] handshake decrements owed[i]. An issue and a handshake in the same cycle leave owed[i] unchanged.
REQ-011 c_out_rdy = FIFO not full. A c_out_vld & c_out_rdy handshake pushes c_out_dat and decrements inflight. Issue and push in the same cycle leave inflight unchanged.
REQ-012 The FIFO SHALL be DEPTH entries, first-word fall-through. m_vld = not empty; m_dat = head entry. A pop on m_vld & m_rdy increments frames_out. Simultaneous push and pop on a full or empty FIFO SHALL be legal and SHALL leave the count unchanged.
REQ-013 The credit gate in REQ-008 guarantees inflight + fifo_cnt <= DEPTH, so c_out_rdy never deasserts because of in-flight work.
REQ-014 Watchdog counter:
- increments while (inflight != 0 or any owed != 0) and there is no push or param handshake that cycle
- clears on any push or param handshake
- at WD_CYC, sets err and enters HALT
REQ-015 In HALT: c_in_vld = s_rdy = p_vld = c_out_rdy = 0; the FIFO still drains to m_*.
REQ-016 frames_in and frames_out SHALL wrap modulo 2^16.

Reset
REQ-017 While reset is high at a clock edge, the block SHALL enter IDLE and clear all state.
REQ-018 Reset values: inflight, owed, FIFO and watchdog counter = 0; busy, done, err, m_vld, c_in_vld, s_rdy, p_vld, c_out_rdy = 0; frames_in = frames_out = 0.
REQ-019 Reset asserted mid-run SHALL discard in-flight and buffered frames, with no done pulse.

Verification
REQ-020 SHALL cover these directed scenarios:
- cfg_count=50, core and downstream always ready, 1 frame/cycle: 50 issues, 50 m_* frames in order; done one cycle after the last pop; frames_in = frames_out = 50.
- m_rdy=0, core always ready, 10 frames offered: exactly DEPTH=4 issues, then s_rdy=0; after m_rdy=1, all 10 are delivered, with no c_out_rdy deassert while c_out_vld=1.
- p_rdy[2] held 0 for 20 cycles over 3 issues: owed[2]=3 and p_vld[2]=1; after release, 3 handshakes, then p_vld[2]=0.
- cfg_stop after 7 issues with 2 in flight: DRAIN, s_rdy=0, both outputs delivered, IDLE, done=1, frames_in=7.
- Core never asserts c_out_vld with 1 in flight, WD_CYC=16: err=1 and HALT at cycle 16; cfg_start is ignored; reset clears err.
- Reset asserted in RUN with 3 in flight: next cycle busy=0, m_vld=0, p_vld=0, no done pulse.

Source files
------------

// File: rtl/econ_infer_sched.sv
// Inference scheduler: meters frames into a compute core under a credit limit,
// tracks per-frame parameter fetches, and buffers results in an FWFT FIFO.
module econ_infer_sched #(
  parameter int IN_W   = 384,
  parameter int OUT_W  = 80,
  parameter int DEPTH  = 4,
  parameter int WD_CYC = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_start,
  input  logic             cfg_stop,
  input  logic [15:0]      cfg_count,
  input  logic [IN_W-1:0]  s_dat,
  input  logic             s_vld,
  output logic             s_rdy,
  output logic [IN_W-1:0]  c_in_dat,
  output logic             c_in_vld,
  input  logic             c_in_rdy,
  output logic [3:0]       p_vld,
  input  logic [3:0]       p_rdy,
  input  logic [OUT_W-1:0] c_out_dat,
  input  logic             c_out_vld,
  output logic             c_out_rdy,
  output logic [OUT_W-1:0] m_dat,
  output logic             m_vld,
  input  logic             m_rdy,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [15:0]      frames_in,
  output logic [15:0]      frames_out
);

  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW     = $clog2(DEPTH + 1);
  localparam int WW     = $clog2(WD_CYC + 1);
  localparam int OWED_W = 16;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, HALT} state_t;

  state_t            state;
  logic [CW-1:0]     inflight;
  logic [CW-1:0]     fifo_cnt;
  logic [OWED_W-1:0] owed [4];
  logic [WW-1:0]     wd_cnt;
  logic [15:0]       count_lat;
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [OUT_W-1:0]  mem [DEPTH];

  logic          active;
  logic [CW:0]   credit_sum;
  logic          credit_ok;
  logic          gate;
  logic          issue;
  logic [3:0]    p_hs;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          pop;
  logic          owed_any;
  logic          wd_active;
  logic          wd_kick;
  logic          wd_expire;
  logic          last_frame;
  logic          drained;

  // Credits cover both core occupancy and FIFO slots, so a result always has room.
  assign active     = (state == RUN) || (state == DRAIN);
  assign credit_sum = {1'b0, inflight} + {1'b0, fifo_cnt};
  assign credit_ok  = credit_sum < (CW+1)'(DEPTH);
  assign gate       = (state == RUN) && credit_ok;

  assign c_in_dat = s_dat;
  assign c_in_vld = s_vld && gate;
  assign s_rdy    = c_in_rdy && gate;
  assign issue    = c_in_vld && c_in_rdy;

  always_comb begin
    for (int i = 0; i < 4; i++) p_vld[i] = (owed[i] != '0) && active;
  end
  assign p_hs = p_vld & p_rdy;

  assign fifo_full  = (fifo_cnt == CW'(DEPTH));
  assign fifo_empty = (fifo_cnt == '0);
  assign c_out_rdy  = !fifo_full && active;
  assign push       = c_out_vld && c_out_rdy;
  assign m_vld      = !fifo_empty;
  assign m_dat      = mem[rd_ptr];
  assign pop        = m_vld && m_rdy;

  assign owed_any   = (owed[0] != '0) || (owed[1] != '0) || (owed[2] != '0) || (owed[3] != '0);
  assign wd_active  = (inflight != '0) || owed_any;
  assign wd_kick    = push || (p_hs != '0);
  assign wd_expire  = (state != HALT) && wd_active && !wd_kick && (wd_cnt == WW'(WD_CYC - 1));
  assign last_frame = issue && (count_lat != '0) && ((frames_in + 16'd1) == count_lat);
  assign drained    = (inflight == '0) && !owed_any && fifo_empty;

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      inflight   <= '0;
      fifo_cnt   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      wd_cnt     <= '0;
      count_lat  <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
      frames_in  <= '0;
      frames_out <= '0;
      for (int i = 0; i < 4; i++) owed[i] <= '0;
    end else begin
      done <= 1'b0;

      if (issue && !push)      inflight <= inflight + CW'(1);
      else if (!issue && push) inflight <= inflight - CW'(1);

      for (int i = 0; i < 4; i++) begin
        if (issue && !p_hs[i])      owed[i] <= owed[i] + OWED_W'(1);
        else if (!issue && p_hs[i]) owed[i] <= owed[i] - OWED_W'(1);
      end

      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      fifo_cnt <= fifo_cnt + CW'(1);
      else if (!push && pop) fifo_cnt <= fifo_cnt - CW'(1);

      if (issue) frames_in  <= frames_in + 16'd1;
      if (pop)   frames_out <= frames_out + 16'd1;

      if (wd_kick)                           wd_cnt <= '0;
      else if (wd_active && state != HALT)   wd_cnt <= wd_cnt + WW'(1);

      case (state)
        IDLE: if (cfg_start) begin
          state      <= RUN;
          frames_in  <= '0;
          frames_out <= '0;
          err        <= 1'b0;
          count_lat  <= cfg_count;
        end
        RUN:   if (cfg_stop || last_frame) state <= DRAIN;
        DRAIN: if (drained) begin
          state <= IDLE;
          done  <= 1'b1;
        end
        default: ;
      endcase

      if (wd_expire) begin
        state <= HALT;
        err   <= 1'b1;
        done  <= 1'b0;
      end
    end
  end

  // Result storage carries data only; occupancy is tracked by the control pointers.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= c_out_dat;
  end

endmodule

// File: tb/tb_econ_infer_sched.sv
// Directed bench for econ_infer_sched: a one-cycle core model plus a second
// instance with a short watchdog for the timeout scenario.
module tb_econ_infer_sched;

  localparam int IN_W  = 384;
  localparam int OUT_W = 80;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset, cfg_start, cfg_stop;
  logic [15:0] cfg_count;
  logic [IN_W-1:0] s_dat;
  logic s_vld, c_in_rdy, c_out_vld, m_rdy;
  logic [3:0] p_rdy;
  logic [OUT_W-1:0] c_out_dat;

  logic s_rdy, c_in_vld, c_out_rdy, m_vld, busy, done, err;
  logic [IN_W-1:0] c_in_dat;
  logic [3:0] p_vld;
  logic [OUT_W-1:0] m_dat;
  logic [15:0] frames_in, frames_out;

  logic w_s_rdy, w_c_in_vld, w_c_out_rdy, w_m_vld, w_busy, w_done, w_err;
  logic [IN_W-1:0] w_c_in_dat;
  logic [3:0] w_p_vld;
  logic [OUT_W-1:0] w_m_dat;
  logic [15:0] w_frames_in, w_frames_out;

  econ_infer_sched #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .WD_CYC(1024)) dut (
    .clk(clk), .reset(reset), .cfg_start(cfg_start), .cfg_stop(cfg_stop), .cfg_count(cfg_count),
    .s_dat(s_dat), .s_vld(s_vld), .s_rdy(s_rdy),
    .c_in_dat(c_in_dat), .c_in_vld(c_in_vld), .c_in_rdy(c_in_rdy),
    .p_vld(p_vld), .p_rdy(p_rdy),
    .c_out_dat(c_out_dat), .c_out_vld(c_out_vld), .c_out_rdy(c_out_rdy),
    .m_dat(m_dat), .m_vld(m_vld), .m_rdy(m_rdy),
    .busy(busy), .done(done), .err(err), .frames_in(frames_in), .frames_out(frames_out)
  );

  econ_infer_sched #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .WD_CYC(16)) dut_wd (
    .clk(clk), .reset(reset), .cfg_start(cfg_start), .cfg_stop(cfg_stop), .cfg_count(cfg_count),
    .s_dat(s_dat), .s_vld(s_vld), .s_rdy(w_s_rdy),
    .c_in_dat(w_c_in_dat), .c_in_vld(w_c_in_vld), .c_in_rdy(c_in_rdy),
    .p_vld(w_p_vld), .p_rdy(p_rdy),
    .c_out_dat(c_out_dat), .c_out_vld(c_out_vld), .c_out_rdy(w_c_out_rdy),
    .m_dat(w_m_dat), .m_vld(w_m_vld), .m_rdy(m_rdy),
    .busy(w_busy), .done(w_done), .err(w_err), .frames_in(w_frames_in), .frames_out(w_frames_out)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  int cyc = 0, issued, delivered, done_cnt, done_cyc, last_pop_cyc, crdy_viol, p2_hs;
  int src_idx, src_lim, n, dc;
  bit core_en;
  logic [OUT_W-1:0] core_q[$];
  logic [OUT_W-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [IN_W-1:0] mk(input int idx);
    logic [IN_W-1:0] f;
    for (int k = 0; k < IN_W/16; k++) f[k*16 +: 16] = 16'(idx*7 + k + 1);
    return f;
  endfunction

  function automatic logic [OUT_W-1:0] xf(input logic [IN_W-1:0] f);
    return f[OUT_W-1:0] ^ 80'h5A5A_5A5A_5A5A_5A5A_5A5A;
  endfunction

  task automatic drive();
    s_vld     = (src_idx < src_lim);
    s_dat     = mk(src_idx);
    c_out_vld = core_en && (core_q.size() > 0);
    c_out_dat = c_out_vld ? core_q[0] : '0;
  endtask

  // Observe handshakes mid-cycle, then advance the core model after the edge.
  task automatic tick();
    logic iss, psh, pp;
    logic [OUT_W-1:0] e;
    @(negedge clk);
    iss = c_in_vld & c_in_rdy;
    psh = c_out_vld & c_out_rdy;
    pp  = m_vld & m_rdy;
    if (c_out_vld && !c_out_rdy) crdy_viol++;
    if (p_vld[2] && p_rdy[2]) p2_hs++;
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (psh) void'(core_q.pop_front());
    if (iss) begin
      core_q.push_back(xf(c_in_dat));
      exp_q.push_back(xf(mk(src_idx)));
      issued++;
      src_idx++;
    end
    if (pp) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : ~m_dat;
      chk("m_dat", m_dat, e);
      delivered++;
      last_pop_cyc = cyc + 1;
    end
    @(posedge clk);
    cyc++;
    #1;
    drive();
  endtask

  task automatic clr();
    issued = 0; delivered = 0; done_cnt = 0; crdy_viol = 0; p2_hs = 0;
    done_cyc = 0; last_pop_cyc = 0; src_idx = 0; src_lim = 0;
  endtask

  task automatic do_reset();
    m_rdy = 1'b0;
    reset = 1'b1;
    core_q.delete();
    exp_q.delete();
    clr();
    drive();
    tick(); tick();
    reset = 1'b0;
    tick();
    m_rdy = 1'b1;
    clr();
  endtask

  task automatic start();
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
  endtask

  task automatic stop();
    cfg_stop = 1'b1;
    tick();
    cfg_stop = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    for (int i = 0; i < bound && done_cnt == 0; i++) tick();
  endtask

  initial begin
    reset = 1'b1; cfg_start = 1'b0; cfg_stop = 1'b0; cfg_count = '0;
    m_rdy = 1'b0; p_rdy = 4'hF; c_in_rdy = 1'b1; core_en = 1'b1;
    clr();
    drive();
    repeat (3) tick();

    // Reset state, with a frame offered while idle.
    src_lim = 100;
    drive();
    reset = 1'b0;
    tick(); tick();
    chk("rst_ctl", {busy, done, err, m_vld, c_in_vld, s_rdy, c_out_rdy}, 7'b0);
    chk("rst_pvld", p_vld, 4'h0);
    chk("rst_frames", {frames_in, frames_out}, 32'h0);
    chk("rst_wd_inst", {w_busy, w_err, w_m_vld}, 3'b0);
    clr();

    // Counted run of 50 with a source offering more than that.
    cfg_count = 16'd50; m_rdy = 1'b1; core_en = 1'b1; src_lim = 60;
    drive();
    start();
    wait_done(400);
    chk("t1_done", done_cnt, 1);
    chk("t1_issued", issued, 50);
    chk("t1_delivered", delivered, 50);
    chk("t1_frames_in", frames_in, 50);
    chk("t1_frames_out", frames_out, 50);
    chk("t1_done_lat", done_cyc - last_pop_cyc, 1);
    src_lim = src_idx; drive();
    tick(); tick();
    chk("t1_done_pulse", {done_cnt, 31'b0, done, busy}, {32'd1, 31'b0, 1'b0, 1'b0});

    // Downstream stalled: credits limit issues to DEPTH.
    clr();
    cfg_count = 16'd0; m_rdy = 1'b0; src_lim = 10;
    drive();
    start();
    repeat (20) tick();
    chk("t2_issued", issued, DEPTH);
    chk("t2_s_rdy", {s_vld, s_rdy}, 2'b10);
    chk("t2_m_vld", m_vld, 1'b1);
    m_rdy = 1'b1;
    for (int i = 0; i < 100 && delivered < 10; i++) tick();
    chk("t2_delivered", delivered, 10);
    chk("t2_crdy_viol", crdy_viol, 0);
    stop();
    wait_done(50);
    chk("t2_done", done_cnt, 1);

    // One parameter channel held off over three issues.
    clr();
    p_rdy = 4'b1011; src_lim = 3;
    drive();
    start();
    repeat (20) tick();
    chk("t3_issued", issued, 3);
    chk("t3_owed2", dut.owed[2], 3);
    chk("t3_pvld", p_vld, 4'b0100);
    chk("t3_p2_held", p2_hs, 0);
    p_rdy = 4'hF;
    repeat (8) tick();
    chk("t3_p2_hs", p2_hs, 3);
    chk("t3_pvld_clr", p_vld, 4'h0);
    chk("t3_delivered", delivered, 3);
    stop();
    wait_done(50);
    chk("t3_done", done_cnt, 1);

    // Stop with two frames still inside the core.
    clr();
    src_lim = 5;
    drive();
    start();
    for (int i = 0; i < 50 && delivered < 5; i++) tick();
    core_en = 1'b0; src_lim = 7;
    drive();
    for (int i = 0; i < 50 && issued < 7; i++) tick();
    chk("t4_inflight", dut.inflight, 2);
    stop();
    src_lim = 20;
    drive();
    tick();
    chk("t4_drain_gate", {busy, s_vld, s_rdy}, 3'b110);
    core_en = 1'b1;
    drive();
    wait_done(50);
    chk("t4_done", done_cnt, 1);
    chk("t4_delivered", delivered, 7);
    chk("t4_frames_in", {issued[15:0], frames_in}, {16'd7, 16'd7});
    chk("t4_idle", busy, 1'b0);

    // Watchdog on the short-timeout instance: core and params both silent.
    do_reset();
    p_rdy = 4'h0; core_en = 1'b0; src_lim = 1;
    drive();
    start();
    for (int i = 0; i < 20 && issued < 1; i++) tick();
    n = 0;
    while (!w_err && n < 40) begin tick(); n++; end
    chk("t5_wd_cycles", n, 16);
    src_lim = 5;
    drive();
    tick();
    chk("t5_halt_gate", {w_busy, w_s_rdy, w_c_in_vld, w_c_out_rdy}, 4'b1000);
    chk("t5_halt_pvld", w_p_vld, 4'h0);
    start();
    tick();
    chk("t5_start_ign", {w_err, w_busy, w_frames_in}, {2'b11, 16'd1});
    do_reset();
    chk("t5_rst_err", {w_err, w_busy}, 2'b00);
    p_rdy = 4'hF;

    // Reset mid-run with three frames inside the core.
    core_en = 1'b0; src_lim = 3;
    drive();
    start();
    for (int i = 0; i < 20 && issued < 3; i++) tick();
    chk("t6_inflight", dut.inflight, 3);
    dc = done_cnt;
    reset = 1'b1; src_lim = src_idx;
    drive();
    tick();
    chk("t6_after_rst", {busy, m_vld, done}, 3'b000);
    chk("t6_pvld", p_vld, 4'h0);
    tick();
    chk("t6_no_done", done_cnt, dc);
    reset = 1'b0;
    core_q.delete();
    exp_q.delete();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
